// File: rtl/hidden_layer_feeder.sv
// Streams input/weight pairs from two synchronous memories to a neuron with valid/ready handshake.
// Define HIDDEN_LAYER_FEEDER_BIAS_EN to append a bias pair (inVal=1, weight=ROM[N_INPUTS]).
module hidden_layer_feeder #(
   parameter int unsigned N_INPUTS = 64,
   parameter int unsigned AW       = 10
) (
   input  logic          Clock,
   input  logic          Clear,
   input  logic          start,
   output logic [AW-1:0] in_addr,
   input  logic [9:0]    in_rdata,
   output logic [AW-1:0] w_addr,
   input  logic [9:0]    w_rdata,
   output logic          acc_clear,
   output logic [9:0]    inVal,
   output logic [9:0]    weight,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

`ifdef HIDDEN_LAYER_FEEDER_BIAS_EN
   localparam bit          BiasEn   = 1'b1;
   localparam int unsigned NumPairs = N_INPUTS + 1;
`else
   localparam bit          BiasEn   = 1'b0;
   localparam int unsigned NumPairs = N_INPUTS;
`endif

   localparam logic [AW-1:0] LastAddr = AW'(NumPairs - 1);
   localparam logic [AW:0]   LastXfer = (AW + 1)'(NumPairs - 1);

   typedef enum logic [1:0] {StIdle, StClr, StStream, StDone} stateT;

   stateT         stateQ, stateD;
   logic [AW-1:0] addrQ, addrD;
   logic [AW:0]   xferQ, xferD;
   logic          pendQ, pendD;
   logic          pendBiasQ, pendBiasD;
   logic          issuedAllQ, issuedAllD;
   logic          outValidQ, outValidD;
   logic [9:0]    inValQ, inValD;
   logic [9:0]    weightQ, weightD;
   logic          skidValidQ, skidValidD;
   logic [9:0]    skidInQ, skidInD;
   logic [9:0]    skidWQ, skidWD;

   logic       fire;
   logic [9:0] arrIn;

   assign fire  = outValidQ & out_ready;
   // Read data returning this cycle; the bias element substitutes a constant 1 for the input.
   assign arrIn = pendBiasQ ? 10'd1 : in_rdata;

   always_comb begin
      stateD     = stateQ;
      addrD      = addrQ;
      xferD      = xferQ;
      pendD      = 1'b0;
      pendBiasD  = 1'b0;
      issuedAllD = issuedAllQ;
      outValidD  = outValidQ;
      inValD     = inValQ;
      weightD    = weightQ;
      skidValidD = skidValidQ;
      skidInD    = skidInQ;
      skidWD     = skidWQ;

      // Output/skid datapath: returning data goes to the output stage if it frees up,
      // otherwise into the skid register.
      if (fire) begin
         if (skidValidQ) begin
            inValD  = skidInQ;
            weightD = skidWQ;
            if (pendQ) begin
               skidInD = arrIn;
               skidWD  = w_rdata;
            end else begin
               skidValidD = 1'b0;
            end
         end else if (pendQ) begin
            inValD  = arrIn;
            weightD = w_rdata;
         end else begin
            outValidD = 1'b0;
         end
      end else if (!outValidQ) begin
         if (pendQ) begin
            outValidD = 1'b1;
            inValD    = arrIn;
            weightD   = w_rdata;
         end
      end else if (pendQ) begin
         skidValidD = 1'b1;
         skidInD    = arrIn;
         skidWD     = w_rdata;
      end

      unique case (stateQ)
         StIdle: begin
            addrD = '0;
            if (start) begin
               stateD = StClr;
            end
         end
         StClr: begin
            pendD      = 1'b1;
            addrD      = addrQ + AW'(1);
            issuedAllD = 1'b0;
            xferD      = '0;
            stateD     = StStream;
         end
         StStream: begin
            // Only issue a read whose data is guaranteed a slot next cycle.
            if (!issuedAllQ && !skidValidD) begin
               pendD     = 1'b1;
               pendBiasD = BiasEn && (addrQ == LastAddr);
               if (addrQ == LastAddr) begin
                  issuedAllD = 1'b1;
               end else begin
                  addrD = addrQ + AW'(1);
               end
            end
            if (fire) begin
               xferD = xferQ + (AW + 1)'(1);
               if (xferQ == LastXfer) begin
                  stateD = StDone;
               end
            end
         end
         StDone: begin
            addrD  = '0;
            stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         stateQ     <= StIdle;
         addrQ      <= '0;
         xferQ      <= '0;
         pendQ      <= 1'b0;
         pendBiasQ  <= 1'b0;
         issuedAllQ <= 1'b0;
         outValidQ  <= 1'b0;
         inValQ     <= '0;
         weightQ    <= '0;
         skidValidQ <= 1'b0;
         skidInQ    <= '0;
         skidWQ     <= '0;
      end else begin
         stateQ     <= stateD;
         addrQ      <= addrD;
         xferQ      <= xferD;
         pendQ      <= pendD;
         pendBiasQ  <= pendBiasD;
         issuedAllQ <= issuedAllD;
         outValidQ  <= outValidD;
         inValQ     <= inValD;
         weightQ    <= weightD;
         skidValidQ <= skidValidD;
         skidInQ    <= skidInD;
         skidWQ     <= skidWD;
      end
   end

   assign in_addr   = addrQ;
   assign w_addr    = addrQ;
   assign inVal     = inValQ;
   assign weight    = weightQ;
   assign out_valid = outValidQ;
   assign acc_clear = (stateQ == StClr);
   assign busy      = (stateQ != StIdle);
   assign done      = (stateQ == StDone);

endmodule

// File: doc/hidden_layer_feeder.md
HIDDEN_LAYER_FEEDER -- requirements
Module: hidden_layer_feeder

Interface
REQ-001 Parameter N_INPUTS, default 64, SHALL set the number of input/weight pairs streamed per neuron pass (2..1024).
REQ-002 Parameter AW, default 10, SHALL set the address width of both memory read ports (2^AW >= N_INPUTS).
REQ-003 Clock  input  1  SHALL be the single clock; all state SHALL change on its rising edge only.
REQ-004 Clear  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request one pass; sampled only in IDLE.
REQ-006 in_addr  output  AW  SHALL be the input-vector RAM read address.
REQ-007 in_rdata  input  10  SHALL be the unsigned input-vector RAM data, valid one cycle after in_addr.
REQ-008 w_addr  output  AW  SHALL be the weight ROM read address, always equal to in_addr.
REQ-009 w_rdata  input  10  SHALL be the signed weight ROM data, valid one cycle after w_addr.
REQ-010 acc_clear  output  1  SHALL be a one-cycle pulse that zeroes the downstream neuron accumulator.
REQ-011 inVal  output  10  SHALL carry the current unsigned input element to the neuron.
REQ-012 weight  output  10  SHALL carry the current signed weight to the neuron.
REQ-013 out_valid  output  1  SHALL mark inVal/weight as a valid pair.
REQ-014 out_ready  input  1  SHALL indicate the neuron accepts the pair; transfer occurs when out_valid and out_ready are both high.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 done  output  1  SHALL pulse one cycle after the last pair transfers.

Function
REQ-017 States SHALL be IDLE, CLR, STREAM, DONE.
REQ-018 IDLE -> CLR when start=1; start in any other state SHALL be ignored.
REQ-019 CLR SHALL last one cycle with acc_clear=1, issue address 0, then go to STREAM.
REQ-020 In STREAM the first pair SHALL appear with out_valid=1 one cycle after entering STREAM (start-to-first-valid latency 3 cycles).
REQ-021 Pairs SHALL be emitted in address order 0..N_INPUTS-1, exactly once each; no duplicates, no skips.
REQ-022 While out_valid=1 and out_ready=0, inVal, weight and out_valid SHALL hold stable; a one-entry skid register SHALL absorb the already-issued read.
REQ-023 With out_ready held high, throughput SHALL be one pair per cycle with no bubbles.
REQ-024 Address SHALL not advance past N_INPUTS-1 and SHALL not wrap within a pass.
REQ-025 After the last pair transfers, STREAM -> DONE; DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-026 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL begin a new pass.
REQ-027 inVal and weight SHALL pass memory data bit-exact; no sign extension or scaling.

Reset
REQ-028 Clear=1 SHALL, at the next edge and regardless of state, force IDLE, addresses 0, inVal=0, weight=0, out_valid=0, acc_clear=0, busy=0, done=0, and empty the skid register.
REQ-029 Clear mid-pass SHALL abort without a done pulse; Clear SHALL take priority over start in the same cycle.

Configuration
REQ-030 With macro HIDDEN_LAYER_FEEDER_BIAS_EN defined, one extra pair SHALL follow element N_INPUTS-1: inVal=10'd1, weight=w_rdata at address N_INPUTS (the stored bias); the ROM SHALL hold N_INPUTS+1 words.
REQ-031 Without HIDDEN_LAYER_FEEDER_BIAS_EN, exactly N_INPUTS pairs SHALL be emitted and address N_INPUTS SHALL never be issued.

Verification
REQ-032 N_INPUTS=4, out_ready=1, start pulse -> acc_clear cycle 1, valid pairs addr 0..3 in cycles 3..6, done in cycle 7, busy low cycle 8.
REQ-033 out_ready low for 3 cycles while addr 1 is presented -> addr 1 data held 4 cycles, then addr 2,3 follow; no loss or duplicate.
REQ-034 out_ready toggling every cycle for full pass -> scoreboard sees all 4 pairs in order, done after last transfer.
REQ-035 Clear asserted while addr 2 is valid -> next cycle all outputs 0, IDLE, no done; new start yields fresh pass from addr 0.
REQ-036 start held high continuously -> back-to-back passes separated by DONE and one IDLE cycle, acc_clear once per pass.
REQ-037 BIAS_EN defined, N_INPUTS=4, ROM[4]=-3 -> fifth pair inVal=1, weight=10'h3FD, then done.
